// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared nibble type, blank code and hex-to-segment decode for seg7_scan
package seg7_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; lower-case b and d keep them distinct from 8 and 0.
  function automatic logic [6:0] hex_to_seg(input nibble_t n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - load-side bus of seg7_scan: hex word, decimal points, load strobe, busy
interface seg7_scan_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] data_in;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic                busy;

  modport master (output data_in, output dp_in, output load, input busy);
  modport slave  (input data_in, input dp_in, input load, output busy);
endinterface

// File: rtl/seg7_tick.sv
// rtl/seg7_tick.sv - digit-slot divider: div_cnt runs 0..SCAN_DIV-1, slot_end flags the last count
module seg7_tick
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_end
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] div_cnt;

  assign slot_end = (div_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (slot_end) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed 7-segment scanner with frame-synchronous commit; SEG7_LZB_EN adds leading-zero blanking
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic              CLK_in,
  input  logic              RST_n,
  seg7_scan_if.slave        bus,
  output logic [DIGITS-1:0] AN,
  output logic [6:0]        SEG,
  output logic              DP,
  output logic              frame_tick
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  logic                slot_end;
  logic                frame_end;
  logic                busy;
  logic                wrap_q;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] pend_data;
  logic [4*DIGITS-1:0] shown_data;
  logic [DIGITS-1:0]   pend_dp;
  logic [DIGITS-1:0]   shown_dp;
  logic [DIGITS-1:0]   blank;
  nibble_t             cur_nib;

  seg7_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk      (CLK_in),
    .rst_n    (RST_n),
    .slot_end (slot_end)
  );

  assign frame_end = slot_end && (idx == LAST_IDX);
  assign bus.busy  = busy;

  always_ff @(posedge CLK_in or negedge RST_n) begin
    if (!RST_n) begin
      idx <= '0;
    end else if (slot_end) begin
      idx <= frame_end ? '0 : idx + 1'b1;
    end
  end

  // Shown registers only change on the frame edge, so one frame never mixes two words.
  always_ff @(posedge CLK_in or negedge RST_n) begin
    if (!RST_n) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      shown_data <= '0;
      shown_dp   <= '0;
      busy       <= 1'b0;
    end else if (frame_end) begin
      if (bus.load) begin
        shown_data <= bus.data_in;
        shown_dp   <= bus.dp_in;
      end else if (busy) begin
        shown_data <= pend_data;
        shown_dp   <= pend_dp;
      end
      busy <= 1'b0;
    end else if (bus.load) begin
      pend_data <= bus.data_in;
      pend_dp   <= bus.dp_in;
      busy      <= 1'b1;
    end
  end

`ifdef SEG7_LZB_EN
  // A digit blanks when it and every digit above it are zero; digit 0 always shows.
  for (genvar g = 0; g < DIGITS; g++) begin : g_blank
    if (g == 0) begin : g_lsd
      assign blank[g] = 1'b0;
    end else begin : g_upper
      assign blank[g] = ~|shown_data[4*DIGITS-1:4*g];
    end
  end
`else
  assign blank = '0;
`endif

  assign cur_nib = shown_data[4*idx +: 4];

  // frame_tick is delayed one extra stage so it lines up with AN returning to digit 0.
  always_ff @(posedge CLK_in or negedge RST_n) begin
    if (!RST_n) begin
      AN         <= '1;
      SEG        <= SEG_BLANK;
      DP         <= 1'b1;
      wrap_q     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      AN         <= ~(DIGITS'(1) << idx);
      SEG        <= blank[idx] ? SEG_BLANK : hex_to_seg(cur_nib);
      DP         <= ~shown_dp[idx];
      wrap_q     <= frame_end;
      frame_tick <= wrap_q;
    end
  end
endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - scoreboard bench for seg7_scan (DIGITS=4, SCAN_DIV=4), optional SEG7_LZB_EN
module tb_seg7_scan;
  localparam int D     = 4;
  localparam int S     = 4;
  localparam int FRAME = D * S;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [D-1:0] an;
  logic [6:0]   seg;
  logic         dp;
  logic         ft;

  seg7_scan_if #(.DIGITS(D)) bus ();

  seg7_scan #(.DIGITS(D), .SCAN_DIV(S)) dut (
    .CLK_in     (clk),
    .RST_n      (rst_n),
    .bus        (bus),
    .AN         (an),
    .SEG        (seg),
    .DP         (dp),
    .frame_tick (ft)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [D-1:0] an;
    logic [6:0]   seg;
    logic         dp;
    logic         ft;
    logic         busy;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   sc       = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int          c;
  int          md;
  logic [15:0] shown_m, pend_m;
  logic [3:0]  sdp_m, pdp_m;
  logic        busy_m;
  exp_t        e_new, e_got;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [15:0] val, input int d);
    logic [15:0] upper;
    upper = val >> (4 * d);
`ifdef SEG7_LZB_EN
    if (d > 0 && upper == 16'h0) return 7'h7F;
`endif
    return seg_tab[upper[3:0]];
  endfunction

  // Reference: cycle c after release shows digit (c/S)%D; the frame edge is the last cycle of each frame.
  always @(posedge clk) begin
    if (!rst_n) begin
      c       = 0;
      shown_m = '0;
      pend_m  = '0;
      sdp_m   = '0;
      pdp_m   = '0;
      busy_m  = 1'b0;
      q.delete();
    end else begin
      md         = (c / S) % D;
      e_new.an   = ~(4'b0001 << md);
      e_new.seg  = exp_seg(shown_m, md);
      e_new.dp   = ~sdp_m[md];
      e_new.ft   = (c > 0) && (c % FRAME == 0);
      if (c % FRAME == FRAME - 1) begin
        if (bus.load) begin
          shown_m = bus.data_in;
          sdp_m   = bus.dp_in;
        end else if (busy_m) begin
          shown_m = pend_m;
          sdp_m   = pdp_m;
        end
        busy_m = 1'b0;
      end else if (bus.load) begin
        pend_m = bus.data_in;
        pdp_m  = bus.dp_in;
        busy_m = 1'b1;
      end
      e_new.busy = busy_m;
      q.push_back(e_new);
      c++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      e_got = q.pop_front();
      chk("AN",         32'(an),       32'(e_got.an));
      chk("SEG",        32'(seg),      32'(e_got.seg));
      chk("DP",         32'(dp),       32'(e_got.dp));
      chk("frame_tick", 32'(ft),       32'(e_got.ft));
      chk("busy",       32'(bus.busy), 32'(e_got.busy));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    sc++;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    bus.data_in = d;
    bus.dp_in   = p;
    bus.load    = 1'b1;
    step();
    bus.load    = 1'b0;
  endtask

  task automatic to_pos(input int pos);
    while (sc % FRAME != pos) step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " AN"},   32'(an),       32'hF);
    chk({tag, " SEG"},  32'(seg),      32'h7F);
    chk({tag, " DP"},   32'(dp),       32'h1);
    chk({tag, " ft"},   32'(ft),       32'h0);
    chk({tag, " busy"}, 32'(bus.busy), 32'h0);
  endtask

  initial begin
    bus.load    = 1'b0;
    bus.data_in = '0;
    bus.dp_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    sc    = 0;
    repeat (40) step();

    to_pos(5);
    do_load(16'h1A2F, 4'h0);
    chk("busy after mid-frame load", 32'(bus.busy), 32'h1);
    repeat (30) step();

    to_pos(2);
    do_load(16'h1111, 4'h0);
    to_pos(9);
    do_load(16'h2222, 4'h0);
    repeat (20) step();

    to_pos(FRAME - 1);
    do_load(16'hBEEF, 4'h0);
    chk("busy after boundary load", 32'(bus.busy), 32'h0);
    repeat (20) step();

    to_pos(3);
    do_load(16'h5678, 4'b0100);
    repeat (36) step();

    to_pos(7);
    do_load(16'h0030, 4'b0001);
    repeat (36) step();

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 12)) step();
      if ($urandom_range(0, 3) == 0) to_pos(FRAME - 1);
      do_load(16'($urandom), 4'($urandom));
    end
    repeat (36) step();

    to_pos(6);
    do_load(16'h9ABC, 4'hF);
    chk("busy with load pending", 32'(bus.busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sc    = 0;
    repeat (40) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
